mdio_multi_phy_poll: RTL and testbench
======================================

// Module: mdio_multi_phy_poll
// PURPOSE
//  Successor MDIO management controller serving NUM_PHY PHYs on one shared MDIO bus.
//  - Issues per-PHY soft resets on request.
//  - Polls BMSR (0x01) and PHYSR (0x11) of every PHY each POLL_CYCLES period.
//  - Publishes per-PHY link/speed status.
//  - Sits between the ETH top-level and the MDIO bit-level driver (op_* handshake).
// PARAMETERS
//  NUM_PHY        2             number of PHYs polled, 1..8
//  PHY_ADDR_BASE  5'h00         MDIO address of PHY 0; PHY i is at PHY_ADDR_BASE+i
//  POLL_CYCLES    1_000_000     clk cycles between poll-round starts, >=16
//  TIMEOUT_CYCLES 65_535        max clk cycles from op_exec to op_done before abort
//  RST_WR_DATA    16'h9140      BMCR value written on soft reset (bit15 = reset)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous, active-high reset
//  soft_rst_trig  in   NUM_PHY    per-PHY reset request; rising edge acts
//  op_done        in   1          driver: operation complete, 1-cycle pulse
//  op_rd_data     in   16         driver: read data, valid with op_done
//  op_rd_ack      in   1          driver: 0 = PHY acked, 1 = no ack
//  op_exec        out  1          start operation, 1-cycle pulse
//  op_rh_wl       out  1          1 = read, 0 = write
//  op_phy_addr    out  5          target PHY address
//  op_addr        out  5          target register address
//  op_wr_data     out  16         write data
//  link_up        out  NUM_PHY    per-PHY link up and autoneg complete
//  speed          out  2*NUM_PHY  per-PHY {11=1000,10=100,01=10,00=down/unknown}; PHY i at [2i+1:2i]
//  bus_err        out  1          sticky: a timeout occurred; cleared by rst only
// BEHAVIOUR
//  Reset values: op_* = 0, link_up = 0, speed = 0, bus_err = 0, FSM = IDLE, timer = 0.
//  Edge detection: 2-flop delay per soft_rst_trig bit; an edge sets rst_pend[i].
//  - An edge in the same cycle as the rst_pend[i] clear leaves rst_pend[i] set.
//  Timer: free-running. Tick at count POLL_CYCLES-1, then wraps to 0.
//  - A tick while not IDLE sets poll_pend; multiple ticks collapse into one.
//  FSM: IDLE -> ISSUE -> WAIT -> EVAL -> IDLE/ISSUE.
//  - IDLE priority 1: any rst_pend. Take the lowest index i; write RST_WR_DATA to reg 0x00.
//  - IDLE priority 2: poll_pend or tick. Set idx = 0 and start a round with a BMSR read.
//  - ISSUE: op_exec = 1 for exactly 1 cycle. op_rh_wl/op_phy_addr/op_addr/op_wr_data
//    are driven that cycle and held stable until op_done or abort.
//  - WAIT: on op_done go to EVAL. After TIMEOUT_CYCLES with no op_done: set bus_err,
//    treat as NACK, go to EVAL.
//  - EVAL, reset write: clear rst_pend[i], link_up[i] = 0, speed[i] = 00; go to IDLE.
//  - EVAL, BMSR, ack = 0 and data[5] & data[2]: read PHYSR of the same PHY.
//  - EVAL, BMSR, otherwise: link_up[idx] = 0, speed[idx] = 00; advance.
//  - EVAL, PHYSR, ack = 0: link_up[idx] = 1; speed from data[15:14]
//    (10 -> 11, 01 -> 10, 00 -> 01, 11 -> 00); advance.
//  - EVAL, PHYSR, NACK: link_up = 0, speed = 00; advance.
//  - Advance: if idx == NUM_PHY-1, clear poll_pend and go to IDLE; else idx + 1 and ISSUE BMSR.
//  Reset requests arriving mid-round wait until the round completes; status never glitches mid-op.
//  op_done outside WAIT is ignored.
//  rst mid-operation: everything returns to reset values in the next cycle; no op_exec follows.
//  Latency: tick -> first op_exec = 2 cycles; op_done -> next op_exec = 2 cycles.
// CONFIGURATION
//  MDIO_LINK_IRQ_EN defined: adds ports irq_clr (in, 1) and link_irq (out, 1).
//  - link_irq is sticky. It sets in the cycle after any link_up or speed bit changes.
//  - irq_clr clears it; a simultaneous change wins.
//  - Reset value 0.
//  MDIO_LINK_IRQ_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package mdio_pkg:
//  - REG_BMCR = 5'h00, REG_BMSR = 5'h01, REG_PHYSR = 5'h11
//  - SPD_1000 / SPD_100 / SPD_10 / SPD_NONE codes
//  - FSM state localparams, op-kind encoding (RST / BMSR / PHYSR)
//  Sub-module mdio_poll_timer: parametrised POLL_CYCLES counter producing the 1-cycle tick.
// TESTING
//  1. NUM_PHY=2, PHY model acks; BMSR = 0x0024, PHYSR = 0x8000 for both ->
//     after one tick, 4 reads (phy 0, 0, 1, 1); link_up = 2'b11, speed = 4'b1111.
//  2. PHY1 BMSR = 0x0004 (autoneg incomplete) -> PHYSR not read for PHY1;
//     link_up = 2'b01, speed[3:2] = 00.
//  3. soft_rst_trig[1] edge during PHY0 BMSR wait -> round completes first; then a write
//     with op_phy_addr = 1, op_addr = 0, op_wr_data = 0x9140; link_up[1] = 0.
//  4. Driver never returns op_done -> abort after TIMEOUT_CYCLES; bus_err = 1;
//     that PHY reads as down; the next PHY is still polled.
//  5. rst asserted in WAIT, then op_done pulses -> no output change; all outputs 0;
//     next op only after a new tick.
//  6. (MDIO_LINK_IRQ_EN) PHYSR 0x8000 -> 0x4000 between rounds -> link_irq = 1;
//     irq_clr pulse -> 0; irq_clr in the same cycle as a change -> stays 1.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared constants, FSM/op-kind encodings and PHYSR speed decode
// for the multi-PHY MDIO poller.
package mdio_pkg;

  localparam logic [4:0] REG_BMCR  = 5'h00;
  localparam logic [4:0] REG_BMSR  = 5'h01;
  localparam logic [4:0] REG_PHYSR = 5'h11;

  localparam logic [1:0] SPD_1000 = 2'b11;
  localparam logic [1:0] SPD_100  = 2'b10;
  localparam logic [1:0] SPD_10   = 2'b01;
  localparam logic [1:0] SPD_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EVAL
  } state_e;

  typedef enum logic [1:0] {
    OP_RST,
    OP_BMSR,
    OP_PHYSR
  } op_e;

  function automatic logic [1:0] physr_spd(input logic [1:0] f);
    unique case (f)
      2'b10:   return SPD_1000;
      2'b01:   return SPD_100;
      2'b00:   return SPD_10;
      default: return SPD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mdio_multi_phy_poll_timer.sv
// Free-running poll period counter; registered 1-cycle tick
// raised when the count reaches POLL_CYCLES-1.
module mdio_poll_timer #(
  parameter int unsigned POLL_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = $clog2(POLL_CYCLES);
  localparam logic [W-1:0] LAST = W'(POLL_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic         tick_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == LAST);
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/mdio_multi_phy_poll.sv
// MDIO management controller: per-PHY soft reset and periodic BMSR/PHYSR poll.
// Optional MDIO_LINK_IRQ_EN adds irq_clr/link_irq (sticky status-change flag).
module mdio_multi_phy_poll
  import mdio_pkg::*;
#(
  parameter int unsigned NUM_PHY        = 2,
  parameter logic [4:0]  PHY_ADDR_BASE  = 5'h00,
  parameter int unsigned POLL_CYCLES    = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 65_535,
  parameter logic [15:0] RST_WR_DATA    = 16'h9140
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PHY-1:0]     soft_rst_trig,
  input  logic                   op_done,
  input  logic [15:0]            op_rd_data,
  input  logic                   op_rd_ack,
  output logic                   op_exec,
  output logic                   op_rh_wl,
  output logic [4:0]             op_phy_addr,
  output logic [4:0]             op_addr,
  output logic [15:0]            op_wr_data,
  output logic [NUM_PHY-1:0]     link_up,
  output logic [2*NUM_PHY-1:0]   speed,
  output logic                   bus_err
`ifdef MDIO_LINK_IRQ_EN
  ,
  input  logic                   irq_clr,
  output logic                   link_irq
`endif
);

  localparam int IW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_PHY - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e               state_q;
  op_e                  kind_q;
  logic [IW-1:0]        idx_q;
  logic [31:0]          to_cnt_q;
  logic                 ack_q;
  logic [15:0]          data_q;
  logic [NUM_PHY-1:0]   trig1_q, trig2_q;
  logic [NUM_PHY-1:0]   rst_pend_q, rst_pend_d, rst_clr;
  logic                 poll_pend_q, poll_pend_d;
  logic                 op_exec_q, op_rh_wl_q;
  logic [4:0]           op_phy_q, op_addr_q;
  logic [15:0]          op_wr_q;
  logic [NUM_PHY-1:0]   link_q;
  logic [2*NUM_PHY-1:0] spd_q;
  logic                 bus_err_q;

  logic          tick;
  logic [IW-1:0] rst_sel;
  logic          rst_any, in_eval, bmsr_ok, adv;
  logic          round_start, round_end;
  logic          st_wr, st_link;
  logic [1:0]    st_spd;
  logic          unused_bits;

  function automatic logic [4:0] phy_addr(input logic [IW-1:0] i);
    return PHY_ADDR_BASE + 5'(i);
  endfunction

  mdio_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_timer (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  always_comb begin
    rst_sel = '0;
    for (int i = NUM_PHY - 1; i >= 0; i--) begin
      if (rst_pend_q[i]) rst_sel = IW'(i);
    end
  end

  assign rst_any     = |rst_pend_q;
  assign in_eval     = (state_q == ST_EVAL);
  assign bmsr_ok     = !ack_q && data_q[5] && data_q[2];
  assign adv         = in_eval && ((kind_q == OP_PHYSR) ||
                                   (kind_q == OP_BMSR && !bmsr_ok));
  assign round_start = (state_q == ST_IDLE) && !rst_any &&
                       (poll_pend_q || tick);
  assign round_end   = adv && (idx_q == LAST);
  assign unused_bits = ^{data_q[13:6], data_q[4:3], data_q[1:0]};

  always_comb begin
    rst_clr = '0;
    if (in_eval && kind_q == OP_RST) rst_clr[idx_q] = 1'b1;
  end

  // An edge arriving together with the clear keeps the request pending.
  assign rst_pend_d  = (rst_pend_q & ~rst_clr) | (trig1_q & ~trig2_q);
  assign poll_pend_d = (poll_pend_q & ~round_end) | (tick & ~round_start);

  always_comb begin
    st_wr   = 1'b0;
    st_link = 1'b0;
    st_spd  = SPD_NONE;
    if (in_eval) begin
      unique case (kind_q)
        OP_RST:  st_wr = 1'b1;
        OP_BMSR: st_wr = !bmsr_ok;
        OP_PHYSR: begin
          st_wr   = 1'b1;
          st_link = !ack_q;
          st_spd  = ack_q ? SPD_NONE : physr_spd(data_q[15:14]);
        end
        default: st_wr = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      kind_q      <= OP_BMSR;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      ack_q       <= 1'b1;
      data_q      <= '0;
      trig1_q     <= '0;
      trig2_q     <= '0;
      rst_pend_q  <= '0;
      poll_pend_q <= 1'b0;
      op_exec_q   <= 1'b0;
      op_rh_wl_q  <= 1'b0;
      op_phy_q    <= '0;
      op_addr_q   <= '0;
      op_wr_q     <= '0;
      link_q      <= '0;
      spd_q       <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      trig1_q     <= soft_rst_trig;
      trig2_q     <= trig1_q;
      rst_pend_q  <= rst_pend_d;
      poll_pend_q <= poll_pend_d;
      op_exec_q   <= 1'b0;
      if (st_wr) begin
        link_q[idx_q]               <= st_link;
        spd_q[{idx_q, 1'b0} +: 2]   <= st_spd;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (rst_any) begin
            state_q    <= ST_ISSUE;
            op_exec_q  <= 1'b1;
            kind_q     <= OP_RST;
            idx_q      <= rst_sel;
            op_rh_wl_q <= 1'b0;
            op_phy_q   <= phy_addr(rst_sel);
            op_addr_q  <= REG_BMCR;
            op_wr_q    <= RST_WR_DATA;
          end else if (round_start) begin
            state_q    <= ST_ISSUE;
            op_exec_q  <= 1'b1;
            kind_q     <= OP_BMSR;
            idx_q      <= '0;
            op_rh_wl_q <= 1'b1;
            op_phy_q   <= phy_addr('0);
            op_addr_q  <= REG_BMSR;
            op_wr_q    <= '0;
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_WAIT;
          to_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (op_done) begin
            state_q <= ST_EVAL;
            ack_q   <= op_rd_ack;
            data_q  <= op_rd_data;
          end else if (to_cnt_q == TO_LAST) begin
            state_q   <= ST_EVAL;
            ack_q     <= 1'b1;
            bus_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_EVAL: begin
          if (kind_q == OP_BMSR && bmsr_ok) begin
            state_q   <= ST_ISSUE;
            op_exec_q <= 1'b1;
            kind_q    <= OP_PHYSR;
            op_addr_q <= REG_PHYSR;
          end else if (adv && idx_q != LAST) begin
            state_q   <= ST_ISSUE;
            op_exec_q <= 1'b1;
            kind_q    <= OP_BMSR;
            idx_q     <= idx_q + 1'b1;
            op_phy_q  <= phy_addr(idx_q + 1'b1);
            op_addr_q <= REG_BMSR;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_exec     = op_exec_q;
  assign op_rh_wl    = op_rh_wl_q;
  assign op_phy_addr = op_phy_q;
  assign op_addr     = op_addr_q;
  assign op_wr_data  = op_wr_q;
  assign link_up     = link_q;
  assign speed       = spd_q;
  assign bus_err     = bus_err_q;

`ifdef MDIO_LINK_IRQ_EN
  logic [NUM_PHY-1:0]   link_prev_q;
  logic [2*NUM_PHY-1:0] spd_prev_q;
  logic                 irq_q;
  logic                 chg;

  assign chg = (link_prev_q != link_q) || (spd_prev_q != spd_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      link_prev_q <= '0;
      spd_prev_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      link_prev_q <= link_q;
      spd_prev_q  <= spd_q;
      irq_q       <= chg | (irq_q & ~irq_clr);
    end
  end

  assign link_irq = irq_q;
`endif

endmodule

// File: tb/tb_mdio_multi_phy_poll.sv
// Directed bench for mdio_multi_phy_poll with a behavioural MDIO driver/PHY model.
// Define MDIO_LINK_IRQ_EN to also exercise the link interrupt.
module tb_mdio_multi_phy_poll;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  soft_rst_trig = 2'b00;
  logic        op_done = 1'b0;
  logic [15:0] op_rd_data = 16'h0;
  logic        op_rd_ack = 1'b1;
  logic        op_exec, op_rh_wl;
  logic [4:0]  op_phy_addr, op_addr;
  logic [15:0] op_wr_data;
  logic [1:0]  link_up;
  logic [3:0]  speed;
  logic        bus_err;
`ifdef MDIO_LINK_IRQ_EN
  logic        irq_clr = 1'b0;
  logic        link_irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] bmsr [2];
  logic [15:0] physr [2];
  logic [1:0]  mute = 2'b00;
  logic [4:0]  log_phy [$];
  logic [4:0]  log_reg [$];
  logic        log_rw [$];
  logic [15:0] log_wd [$];
  int          log_cyc [$];
  int          done_cyc [$];

  mdio_multi_phy_poll #(
    .NUM_PHY       (2),
    .PHY_ADDR_BASE (5'h00),
    .POLL_CYCLES   (200),
    .TIMEOUT_CYCLES(40),
    .RST_WR_DATA   (16'h9140)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_trig(soft_rst_trig),
    .op_done      (op_done),
    .op_rd_data   (op_rd_data),
    .op_rd_ack    (op_rd_ack),
    .op_exec      (op_exec),
    .op_rh_wl     (op_rh_wl),
    .op_phy_addr  (op_phy_addr),
    .op_addr      (op_addr),
    .op_wr_data   (op_wr_data),
    .link_up      (link_up),
    .speed        (speed),
    .bus_err      (bus_err)
`ifdef MDIO_LINK_IRQ_EN
    ,
    .irq_clr      (irq_clr),
    .link_irq     (link_irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver/PHY model: log each op, answer two cycles later unless muted.
  initial begin
    logic       mp;
    logic [4:0] r;
    forever begin
      @(negedge clk);
      if (op_exec === 1'b1) begin
        log_phy.push_back(op_phy_addr);
        log_reg.push_back(op_addr);
        log_rw.push_back(op_rh_wl);
        log_wd.push_back(op_wr_data);
        log_cyc.push_back(cyc);
        mp = op_phy_addr[0];
        r  = op_addr;
        if (!mute[mp]) begin
          repeat (2) @(negedge clk);
          op_done    = 1'b1;
          op_rd_ack  = 1'b0;
          op_rd_data = (r == 5'h01) ? bmsr[mp] :
                       (r == 5'h11) ? physr[mp] : 16'h0;
          done_cyc.push_back(cyc);
          @(negedge clk);
          op_done    = 1'b0;
          op_rd_ack  = 1'b1;
          op_rd_data = 16'h0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log_phy.delete();
    log_reg.delete();
    log_rw.delete();
    log_wd.delete();
    log_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_ops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (log_phy.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (op_exec !== 1'b0 || op_rh_wl !== 1'b0) begin
      errors++;
      $display("FAIL rst_op_ctl: got %b%b exp 00", op_exec, op_rh_wl);
    end
    checks++;
    if ({op_phy_addr, op_addr, op_wr_data} !== 26'h0) begin
      errors++;
      $display("FAIL rst_op_fields: got %h exp 0",
               {op_phy_addr, op_addr, op_wr_data});
    end
    checks++;
    if (link_up !== 2'b00 || speed !== 4'b0000) begin
      errors++;
      $display("FAIL rst_status: got %b %b exp 00 0000", link_up, speed);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_err: got %b exp 0", bus_err);
    end
    do_reset();
    repeat (150) @(negedge clk);
    checks++;
    if (log_phy.size() != 0) begin
      errors++;
      $display("FAIL rst_no_early_op: got %0d ops exp 0", log_phy.size());
    end
  endtask

  task automatic test_poll_all;
    bit ok;
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h8000, 16'h8000};
    do_reset();
    wait_ops(4, 400, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL poll_ops_seen: got %0d ops exp 4", log_phy.size());
    end
    checks++;
    if (log_phy.size() != 4) begin
      errors++;
      $display("FAIL poll_op_count: got %0d exp 4", log_phy.size());
    end
    checks++;
    if ({log_phy[0], log_phy[1], log_phy[2], log_phy[3]} !==
        {5'd0, 5'd0, 5'd1, 5'd1}) begin
      errors++;
      $display("FAIL poll_phy_seq: got %0d %0d %0d %0d exp 0 0 1 1",
               log_phy[0], log_phy[1], log_phy[2], log_phy[3]);
    end
    checks++;
    if ({log_reg[0], log_reg[1], log_reg[2], log_reg[3]} !==
        {5'h01, 5'h11, 5'h01, 5'h11}) begin
      errors++;
      $display("FAIL poll_reg_seq: got %h %h %h %h exp 01 11 01 11",
               log_reg[0], log_reg[1], log_reg[2], log_reg[3]);
    end
    checks++;
    if ({log_rw[0], log_rw[1], log_rw[2], log_rw[3]} !== 4'b1111) begin
      errors++;
      $display("FAIL poll_read_dir: got %b%b%b%b exp 1111",
               log_rw[0], log_rw[1], log_rw[2], log_rw[3]);
    end
    checks++;
    if (log_cyc[1] - done_cyc[0] != 2) begin
      errors++;
      $display("FAIL poll_latency_same_phy: got %0d exp 2",
               log_cyc[1] - done_cyc[0]);
    end
    checks++;
    if (log_cyc[2] - done_cyc[1] != 2) begin
      errors++;
      $display("FAIL poll_latency_next_phy: got %0d exp 2",
               log_cyc[2] - done_cyc[1]);
    end
    checks++;
    if (link_up !== 2'b11 || speed !== 4'b1111) begin
      errors++;
      $display("FAIL poll_status: got %b %b exp 11 1111", link_up, speed);
    end
  endtask

  task automatic test_speed_map;
    bit ok;
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h0000, 16'hC000};
    do_reset();
    wait_ops(4, 400, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL spdmap_ops_seen: got %0d ops exp 4", log_phy.size());
    end
    checks++;
    if (link_up !== 2'b11 || speed !== 4'b0001) begin
      errors++;
      $display("FAIL spdmap_status: got %b %b exp 11 0001", link_up, speed);
    end
  endtask

  task automatic test_autoneg;
    bit ok;
    bmsr  = '{16'h0024, 16'h0004};
    physr = '{16'h4000, 16'h8000};
    do_reset();
    wait_ops(3, 400, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL aneg_ops_seen: got %0d ops exp 3", log_phy.size());
    end
    checks++;
    if (log_phy.size() != 3) begin
      errors++;
      $display("FAIL aneg_no_physr: got %0d ops exp 3", log_phy.size());
    end
    checks++;
    if ({log_phy[2], log_reg[2]} !== {5'd1, 5'h01}) begin
      errors++;
      $display("FAIL aneg_last_op: got %0d/%h exp 1/01",
               log_phy[2], log_reg[2]);
    end
    checks++;
    if (link_up !== 2'b01 || speed !== 4'b0010) begin
      errors++;
      $display("FAIL aneg_status: got %b %b exp 01 0010", link_up, speed);
    end
  endtask

  task automatic test_soft_reset;
    bit ok;
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h8000, 16'h8000};
    do_reset();
    wait_ops(1, 400, ok);
    soft_rst_trig = 2'b10;
    repeat (3) @(negedge clk);
    soft_rst_trig = 2'b00;
    wait_ops(5, 400, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || log_phy.size() != 5) begin
      errors++;
      $display("FAIL srst_op_count: got %0d exp 5", log_phy.size());
    end
    checks++;
    if ({log_phy[3], log_reg[3], log_rw[3]} !== {5'd1, 5'h11, 1'b1}) begin
      errors++;
      $display("FAIL srst_round_first: got %0d/%h/%b exp 1/11/1",
               log_phy[3], log_reg[3], log_rw[3]);
    end
    checks++;
    if ({log_phy[4], log_reg[4], log_rw[4]} !== {5'd1, 5'h00, 1'b0}) begin
      errors++;
      $display("FAIL srst_write_op: got %0d/%h/%b exp 1/00/0",
               log_phy[4], log_reg[4], log_rw[4]);
    end
    checks++;
    if (log_wd[4] !== 16'h9140) begin
      errors++;
      $display("FAIL srst_wr_data: got %h exp 9140", log_wd[4]);
    end
    checks++;
    if (link_up !== 2'b01 || speed !== 4'b0011) begin
      errors++;
      $display("FAIL srst_status: got %b %b exp 01 0011", link_up, speed);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h8000, 16'h8000};
    mute  = 2'b01;
    do_reset();
    wait_ops(1, 400, ok);
    repeat (28) @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_not_early: got %b exp 0", bus_err);
    end
    wait_ops(3, 200, ok);
    repeat (10) @(negedge clk);
    mute = 2'b00;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_next_phy_polled: got %0d ops exp 3", log_phy.size());
    end
    checks++;
    if ({log_phy[1], log_reg[1]} !== {5'd1, 5'h01}) begin
      errors++;
      $display("FAIL tmo_second_op: got %0d/%h exp 1/01",
               log_phy[1], log_reg[1]);
    end
    checks++;
    if (bus_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_bus_err: got %b exp 1", bus_err);
    end
    checks++;
    if (link_up !== 2'b10 || speed !== 4'b1100) begin
      errors++;
      $display("FAIL tmo_status: got %b %b exp 10 1100", link_up, speed);
    end
  endtask

  task automatic test_rst_mid;
    bit ok;
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h8000, 16'h8000};
    do_reset();
    wait_ops(4, 400, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (link_up !== 2'b11) begin
      errors++;
      $display("FAIL rmid_pre_link: got %b exp 11", link_up);
    end
    wait_ops(5, 400, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({op_exec, op_rh_wl, op_phy_addr, op_addr, op_wr_data,
         link_up, speed, bus_err} !== 35'h0) begin
      errors++;
      $display("FAIL rmid_outputs_zero: got %h exp 0",
               {op_exec, op_rh_wl, op_phy_addr, op_addr, op_wr_data,
                link_up, speed, bus_err});
    end
    repeat (100) @(negedge clk);
    checks++;
    if (log_phy.size() != 5 || link_up !== 2'b00) begin
      errors++;
      $display("FAIL rmid_quiet: got %0d ops link %b exp 5 ops link 00",
               log_phy.size(), link_up);
    end
    wait_ops(6, 400, ok);
    checks++;
    if (!ok || {log_phy[5], log_reg[5]} !== {5'd0, 5'h01}) begin
      errors++;
      $display("FAIL rmid_next_tick_op: got %0d ops exp 6 with 0/01",
               log_phy.size());
    end
    repeat (30) @(negedge clk);
  endtask

`ifdef MDIO_LINK_IRQ_EN
  task automatic test_link_irq;
    bit ok;
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h8000, 16'h8000};
    do_reset();
    wait_ops(4, 400, ok);
    repeat (10) @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (link_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_cleared_first: got %b exp 0", link_irq);
    end
    physr = '{16'h4000, 16'h4000};
    wait_ops(8, 400, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (link_irq !== 1'b1 || speed !== 4'b1010) begin
      errors++;
      $display("FAIL irq_on_change: got %b %b exp 1 1010", link_irq, speed);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (link_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr: got %b exp 0", link_irq);
    end
    physr = '{16'h8000, 16'h8000};
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (speed !== 4'b1010) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (!ok || link_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_change_beats_clr: got %b exp 1", link_irq);
    end
  endtask
`endif

  initial begin
    bmsr  = '{16'h0024, 16'h0024};
    physr = '{16'h8000, 16'h8000};
    test_reset();
    test_poll_all();
    test_speed_map();
    test_autoneg();
    test_soft_reset();
    test_timeout();
    test_rst_mid();
`ifdef MDIO_LINK_IRQ_EN
    test_link_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
